hrtf_conv_scheduler: RTL and testbench
======================================

HRTF_CONV_SCHEDULER -- requirements
Module: hrtf_conv_scheduler

Interface
REQ-001 Parameter: TAPS, default 128, taps per ear pass; fixed at 128 (tap field is 7 bits).
REQ-002 Parameter: BRAM_LAT, default 1, BRAM read latency in cycles; legal range 1..3.
REQ-003 Port: clk  in  1  single clock; all logic is rising-edge.
REQ-004 Port: reset_n  in  1  asynchronous, active-low reset.
REQ-005 Port: sample_trig  in  1  one-cycle pulse per audio sample, from I2S.
REQ-006 Port: angle_index  in  8  HRTF angle select; sampled only on trigger acceptance.
REQ-007 Port: clr_overrun  in  1  clears the sticky overrun flag.
REQ-008 Port: bram_addr  out  16  coefficient address = {ear, angle, tap[6:0]}.
REQ-009 Port: bram_en  out  1  BRAM read enable; high only while an address is issued.
REQ-010 Port: mac_en  out  1  MAC accumulate enable; aligned with BRAM read data.
REQ-011 Port: mac_clr  out  1  high with the first mac_en of each ear pass (tap 0).
REQ-012 Port: mac_last  out  1  high with the final mac_en of each ear pass (tap 127).
REQ-013 Port: mac_ear  out  1  ear of the current mac_en data: 0 = left, 1 = right.
REQ-014 Port: busy  out  1  high whenever state is not IDLE.
REQ-015 Port: done  out  1  one-cycle pulse after both ear passes complete.
REQ-016 Port: overrun  out  1  sticky; set when a trigger arrives while busy.

Function
REQ-017 FSM states: IDLE, RUN, DRAIN; ear bit and 7-bit tap counter held in registers.
REQ-018 IDLE + sample_trig: latch angle_index, set ear=0 and tap=0, go to RUN.
REQ-019 RUN: assert bram_en with bram_addr={ear,angle_lat,tap}; tap increments every cycle.
REQ-020 RUN at tap=127: go to DRAIN for exactly BRAM_LAT cycles; bram_en is low in DRAIN.
REQ-021 DRAIN end, ear=0: set ear=1 and tap=0, return to RUN (right pass).
REQ-022 DRAIN end, ear=1: go to IDLE; done is high for the first IDLE cycle only.
REQ-023 All outputs are registered; trigger at cycle T gives the first bram_en at T+1.
REQ-024 mac_en, mac_clr, mac_last and mac_ear are the issue-side bram_en, tap==0, tap==127 and ear, each delayed by BRAM_LAT cycles.
REQ-025 Timing per trigger: 128 issues per ear, 256 total; done at T+257+2*BRAM_LAT (T+259 for BRAM_LAT=1).
REQ-026 The address arithmetic is pure concatenation; no carry crosses into the angle or ear fields.
REQ-027 The latched angle is held for both passes; angle_index changes mid-operation have no effect.
REQ-028 Trigger while busy: the trigger is dropped, the sequence continues unaffected, and overrun is set.
REQ-029 Trigger in the done cycle (state IDLE): the trigger is accepted normally.
REQ-030 Overrun set and clr_overrun in the same cycle: set wins.
REQ-031 clr_overrun with no new overrun: overrun is low on the next cycle.

Reset
REQ-032 reset_n low: all outputs and internal state go to 0 (IDLE, ear=0, tap=0, delay pipes empty) immediately, without waiting for clk.
REQ-033 Reset mid-pass: the pass is aborted with no done pulse, mac_en is low from reset assertion, and a trigger after release starts a fresh sequence.

Verification
REQ-034 Single trigger, angle=0x05, BRAM_LAT=1: addresses 0x0280..0x02FF then 0x8280..0x82FF; 256 mac_en; done at T+259.
REQ-035 mac alignment: mac_clr coincides with the first mac_en of each pass and mac_last with the 128th; exactly two of each per trigger; mac_ear is 0 then 1.
REQ-036 Second trigger at T+50 with angle changed to 0x10: it is ignored, all addresses still use 0x05, and overrun=1 until a clr_overrun pulse.
REQ-037 Trigger in the done cycle: a new sequence starts the next cycle and the first address is {0,angle,0}.
REQ-038 reset_n low at T+100: outputs are 0 within the same cycle, there is no done pulse, and a subsequent trigger gives the full 259-cycle sequence.
REQ-039 BRAM_LAT=3, angle=0xFF: last address is 0xFFFF; mac_en lags bram_en by 3 cycles; done at T+263.

Source files
------------

// File: rtl/hrtf_conv_scheduler.sv
// Sequences the left then right HRTF coefficient reads for one audio sample and
// emits MAC control strobes delayed to line up with the BRAM read data.
module hrtf_conv_scheduler #(
   parameter int TAPS     = 128,
   parameter int BRAM_LAT = 1
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        sample_trig,
   input  logic [7:0]  angle_index,
   input  logic        clr_overrun,
   output logic [15:0] bram_addr,
   output logic        bram_en,
   output logic        mac_en,
   output logic        mac_clr,
   output logic        mac_last,
   output logic        mac_ear,
   output logic        busy,
   output logic        done,
   output logic        overrun
);

   localparam logic [6:0] LAST_TAP  = 7'(TAPS - 1);
   localparam logic [1:0] DRAIN_END = 2'(BRAM_LAT - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2
   } state_e;

   state_e      state_q, state_d;
   logic        ear_q, ear_d;
   logic [6:0]  tap_q, tap_d;
   logic [7:0]  angle_q, angle_d;
   logic [1:0]  drain_q, drain_d;

   logic        bram_en_d;
   logic [15:0] bram_addr_d;
   logic        busy_d, done_d, overrun_d;
   logic [3:0]  mac_src_s;
   logic [3:0]  mac_pipe_q [BRAM_LAT];

   // FSM state and sequencing counters.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         ear_q   <= 1'b0;
         tap_q   <= 7'd0;
         angle_q <= 8'd0;
         drain_q <= 2'd0;
      end else begin
         state_q <= state_d;
         ear_q   <= ear_d;
         tap_q   <= tap_d;
         angle_q <= angle_d;
         drain_q <= drain_d;
      end
   end

   // Next-state logic: the registered tap/ear always describe the address on the bus.
   always_comb begin
      state_d = state_q;
      ear_d   = ear_q;
      tap_d   = tap_q;
      angle_d = angle_q;
      drain_d = drain_q;
      case (state_q)
         S_IDLE: begin
            if (sample_trig) begin
               state_d = S_RUN;
               ear_d   = 1'b0;
               tap_d   = 7'd0;
               angle_d = angle_index;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_RUN: begin
            drain_d = 2'd0;
            if (tap_q == LAST_TAP) begin
               state_d = S_DRAIN;
            end else begin
               tap_d = tap_q + 7'd1;
            end
         end
         S_DRAIN: begin
            if (drain_q == DRAIN_END) begin
               tap_d = 7'd0;
               if (!ear_q) begin
                  state_d = S_RUN;
                  ear_d   = 1'b1;
               end else begin
                  state_d = S_IDLE;
                  ear_d   = 1'b0;
               end
            end else begin
               drain_d = drain_q + 2'd1;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Output decode, computed one cycle ahead so every port comes straight from a flop.
   always_comb begin
      bram_en_d   = (state_d == S_RUN);
      bram_addr_d = bram_en_d ? {ear_d, angle_d, tap_d} : 16'h0000;
      busy_d      = (state_d != S_IDLE);
      done_d      = (state_q == S_DRAIN) && (drain_q == DRAIN_END) && ear_q;
      if (sample_trig && (state_q != S_IDLE)) begin
         overrun_d = 1'b1;
      end else if (clr_overrun) begin
         overrun_d = 1'b0;
      end else begin
         overrun_d = overrun;
      end
      mac_src_s = {bram_en,
                   bram_en && (bram_addr[6:0] == 7'd0),
                   bram_en && (bram_addr[6:0] == LAST_TAP),
                   bram_en && bram_addr[15]};
   end

   // Output registers and the BRAM-latency delay line for the MAC strobes.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         bram_en   <= 1'b0;
         bram_addr <= 16'h0000;
         busy      <= 1'b0;
         done      <= 1'b0;
         overrun   <= 1'b0;
         for (int i = 0; i < BRAM_LAT; i++) begin
            mac_pipe_q[i] <= 4'd0;
         end
      end else begin
         bram_en   <= bram_en_d;
         bram_addr <= bram_addr_d;
         busy      <= busy_d;
         done      <= done_d;
         overrun   <= overrun_d;
         mac_pipe_q[0] <= mac_src_s;
         for (int i = 1; i < BRAM_LAT; i++) begin
            mac_pipe_q[i] <= mac_pipe_q[i-1];
         end
      end
   end

   assign mac_en   = mac_pipe_q[BRAM_LAT-1][3];
   assign mac_clr  = mac_pipe_q[BRAM_LAT-1][2];
   assign mac_last = mac_pipe_q[BRAM_LAT-1][1];
   assign mac_ear  = mac_pipe_q[BRAM_LAT-1][0];

endmodule

// File: tb/tb_hrtf_conv_scheduler.sv
// Bench for hrtf_conv_scheduler: two instances (BRAM_LAT 1 and 3) share one stimulus
// stream and are checked every cycle against an offset-from-trigger timing model.
module tb_hrtf_conv_scheduler;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset_n, sample_trig, clr_overrun;
   logic [7:0]  angle_index;
   logic [15:0] addr_a, addr_b;
   logic en_a, me_a, mc_a, ml_a, mr_a, busy_a, done_a, ovr_a;
   logic en_b, me_b, mc_b, ml_b, mr_b, busy_b, done_b, ovr_b;

   hrtf_conv_scheduler #(.TAPS(128), .BRAM_LAT(1)) dut_l1 (
      .clk(clk), .reset_n(reset_n), .sample_trig(sample_trig), .angle_index(angle_index),
      .clr_overrun(clr_overrun), .bram_addr(addr_a), .bram_en(en_a), .mac_en(me_a),
      .mac_clr(mc_a), .mac_last(ml_a), .mac_ear(mr_a), .busy(busy_a), .done(done_a),
      .overrun(ovr_a));

   hrtf_conv_scheduler #(.TAPS(128), .BRAM_LAT(3)) dut_l3 (
      .clk(clk), .reset_n(reset_n), .sample_trig(sample_trig), .angle_index(angle_index),
      .clr_overrun(clr_overrun), .bram_addr(addr_b), .bram_en(en_b), .mac_en(me_b),
      .mac_clr(mc_b), .mac_last(ml_b), .mac_ear(mr_b), .busy(busy_b), .done(done_b),
      .overrun(ovr_b));

   int tests = 0;
   int fails = 0;
   int cyc = 0;
   int lat [2] = '{1, 3};
   bit act [2];
   int k [2];
   logic [7:0] ang [2];
   bit ovr [2];
   int mac_cnt [2];
   int clr_cnt [2];
   int last_cnt [2];

   // Issue at offset kk after the trigger: left taps at 1..128, right after L idle cycles.
   function automatic void issue(input int kk, input int L, input logic [7:0] a,
                                 output bit en, output logic [15:0] ad);
      en = 1'b0;
      ad = 16'h0000;
      if (kk >= 1 && kk <= 128) begin
         en = 1'b1;
         ad = {1'b0, a, 7'(kk - 1)};
      end else if (kk >= 129 + L && kk <= 256 + L) begin
         en = 1'b1;
         ad = {1'b1, a, 7'(kk - 129 - L)};
      end
   endfunction

   task automatic chkb(input string nm, input int i, input logic a, input logic e);
      tests++;
      if (a !== e) begin
         fails++;
         $display("FAIL %s lat%0d cyc %0d: got %b expected %b", nm, lat[i], cyc, a, e);
      end
   endtask

   task automatic chkw(input string nm, input int i, input logic [15:0] a, input logic [15:0] e);
      tests++;
      if (a !== e) begin
         fails++;
         $display("FAIL %s lat%0d cyc %0d: got %h expected %h", nm, lat[i], cyc, a, e);
      end
   endtask

   task automatic chki(input string nm, input int i, input int a, input int e);
      tests++;
      if (a != e) begin
         fails++;
         $display("FAIL %s lat%0d cyc %0d: got %0d expected %0d", nm, lat[i], cyc, a, e);
      end
   endtask

   task automatic check_lane(input int i, input logic [15:0] ad, input logic en, input logic me,
                             input logic mc, input logic ml, input logic mr, input logic bz,
                             input logic dn, input logic ov);
      bit e_en, e_me;
      logic [15:0] e_ad, e_ma;
      int kk, L;
      L  = lat[i];
      kk = act[i] ? k[i] : -1000;
      issue(kk, L, ang[i], e_en, e_ad);
      issue(kk - L, L, ang[i], e_me, e_ma);
      chkb("bram_en", i, en, e_en);
      if (e_en) chkw("bram_addr", i, ad, e_ad);
      chkb("mac_en", i, me, e_me);
      chkb("mac_clr", i, mc, e_me && (e_ma[6:0] == 7'd0));
      chkb("mac_last", i, ml, e_me && (e_ma[6:0] == 7'd127));
      if (e_me) chkb("mac_ear", i, mr, e_ma[15]);
      chkb("busy", i, bz, act[i] && kk >= 1 && kk <= 256 + 2 * L);
      chkb("done", i, dn, act[i] && kk == 257 + 2 * L);
      chkb("overrun", i, ov, ovr[i]);
   endtask

   task automatic check_all();
      check_lane(0, addr_a, en_a, me_a, mc_a, ml_a, mr_a, busy_a, done_a, ovr_a);
      check_lane(1, addr_b, en_b, me_b, mc_b, ml_b, mr_b, busy_b, done_b, ovr_b);
   endtask

   task automatic clear_model();
      for (int i = 0; i < 2; i++) begin
         act[i] = 1'b0;
         k[i]   = 0;
         ang[i] = 8'h00;
         ovr[i] = 1'b0;
      end
   endtask

   task automatic model_update(input int i);
      bit idle;
      idle = !act[i] || (k[i] >= 257 + 2 * lat[i]);
      if (sample_trig && !idle) ovr[i] = 1'b1;
      else if (clr_overrun) ovr[i] = 1'b0;
      if (sample_trig && idle) begin
         act[i] = 1'b1;
         k[i]   = 1;
         ang[i] = angle_index;
      end else if (act[i]) begin
         if (k[i] >= 257 + 2 * lat[i]) act[i] = 1'b0;
         else k[i] = k[i] + 1;
      end
   endtask

   task automatic step();
      @(posedge clk);
      cyc++;
      if (!reset_n) clear_model();
      else begin
         model_update(0);
         model_update(1);
      end
      @(negedge clk);
      check_all();
      if (me_a) mac_cnt[0]++;
      if (mc_a) clr_cnt[0]++;
      if (ml_a) last_cnt[0]++;
      if (me_b) mac_cnt[1]++;
      if (mc_b) clr_cnt[1]++;
      if (ml_b) last_cnt[1]++;
   endtask

   task automatic run_to(input int target);
      while (cyc < target) step();
   endtask

   task automatic trigger(input logic [7:0] a, output int t);
      t = cyc;
      sample_trig = 1'b1;
      angle_index = a;
      step();
      sample_trig = 1'b0;
   endtask

   initial begin
      int t, t2, t3, t4, t5;
      int m0, c0, l0, m1, c1, l1;
      reset_n     = 1'b0;
      sample_trig = 1'b0;
      clr_overrun = 1'b0;
      angle_index = 8'h00;
      clear_model();
      for (int i = 0; i < 2; i++) begin
         mac_cnt[i] = 0; clr_cnt[i] = 0; last_cnt[i] = 0;
      end
      step();
      step();
      chkw("reset_addr", 0, addr_a, 16'h0000);
      chkb("reset_busy", 1, busy_b, 1'b0);
      reset_n = 1'b1;
      step();
      step();

      // Single trigger, angle 0x05, with a dropped trigger at T+50.
      m0 = mac_cnt[0]; c0 = clr_cnt[0]; l0 = last_cnt[0];
      m1 = mac_cnt[1]; c1 = clr_cnt[1]; l1 = last_cnt[1];
      trigger(8'h05, t);
      chkw("pin_first_addr", 0, addr_a, 16'h0280);
      chkb("pin_first_en", 0, en_a, 1'b1);
      run_to(t + 50);
      sample_trig = 1'b1;
      angle_index = 8'h10;
      clr_overrun = 1'b1;
      step();
      sample_trig = 1'b0;
      clr_overrun = 1'b0;
      chkb("pin_ovr_set_wins", 0, ovr_a, 1'b1);
      chkb("pin_ovr_set_wins", 1, ovr_b, 1'b1);
      run_to(t + 60);
      clr_overrun = 1'b1;
      step();
      clr_overrun = 1'b0;
      chkb("pin_ovr_clr", 0, ovr_a, 1'b0);
      chkb("pin_ovr_clr", 1, ovr_b, 1'b0);
      run_to(t + 128);
      chkw("pin_left_last", 0, addr_a, 16'h02FF);
      step();
      chkb("pin_drain_en", 0, en_a, 1'b0);
      step();
      chkw("pin_right_first", 0, addr_a, 16'h8280);
      run_to(t + 258);
      chkb("pin_no_early_done", 0, done_a, 1'b0);
      step();
      chkb("pin_done_259", 0, done_a, 1'b1);
      chkw("pin_right_last", 1, addr_b, 16'h82FF);
      chki("pin_mac_count", 0, mac_cnt[0] - m0, 256);
      chki("pin_clr_count", 0, clr_cnt[0] - c0, 2);
      chki("pin_last_count", 0, last_cnt[0] - l0, 2);

      // Trigger in the done cycle of the latency-1 lane (latency-3 lane still busy).
      trigger(8'hFF, t2);
      chkw("pin_done_cycle_start", 0, addr_a, 16'h7F80);
      chkb("pin_l3_overrun", 1, ovr_b, 1'b1);
      run_to(t + 263);
      chkb("pin_done_263", 1, done_b, 1'b1);
      chki("pin_mac_count", 1, mac_cnt[1] - m1, 256);
      chki("pin_clr_count", 1, clr_cnt[1] - c1, 2);
      chki("pin_last_count", 1, last_cnt[1] - l1, 2);
      run_to(t2 + 262);

      // Latency 3, angle 0xFF.
      trigger(8'hFF, t3);
      chkb("pin_l3_mac_lag", 1, me_b, 1'b0);
      run_to(t3 + 4);
      chkb("pin_l3_mac_first", 1, me_b, 1'b1);
      chkb("pin_l3_clr_first", 1, mc_b, 1'b1);
      run_to(t3 + 259);
      chkw("pin_l3_last_addr", 1, addr_b, 16'hFFFF);
      run_to(t3 + 262);
      chkb("pin_l3_mac_last", 1, ml_b, 1'b1);
      step();
      chkb("pin_l3_done", 1, done_b, 1'b1);
      run_to(t3 + 266);

      // Reset mid-pass, then a fresh full sequence.
      trigger(8'h22, t4);
      run_to(t4 + 100);
      reset_n = 1'b0;
      #1;
      clear_model();
      check_all();
      chkb("pin_reset_bram_en", 0, en_a, 1'b0);
      chkb("pin_reset_mac_en", 0, me_a, 1'b0);
      @(negedge clk);
      step();
      reset_n = 1'b1;
      step();
      trigger(8'h22, t5);
      chkw("pin_fresh_first", 0, addr_a, 16'h1100);
      run_to(t5 + 259);
      chkb("pin_fresh_done", 0, done_a, 1'b1);
      run_to(t5 + 266);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
